// File: rtl/bus_arbiter_pkg.sv
`default_nettype none
//==========================================================================
// Module : bus_arbiter_pkg
// Shared FSM state encoding and sizing constants for the bus arbiter.
// Rev    : 1.0
//==========================================================================
package bus_arbiter_pkg;

  localparam int MAX_MASTERS            = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64;
  localparam int INDEX_W                = $clog2(MAX_MASTERS);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_BUSY    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  // Seeding last_winner with the top index makes master 0 the first winner.
  function automatic logic [INDEX_W-1:0] last_index(input int num_masters);
    return INDEX_W'(num_masters - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_rr_select.sv
`default_nettype none
//==========================================================================
// Module : bus_arbiter_rr_select
// Combinational round-robin pick: first request above last_winner, else wrap.
// Rev    : 1.0
//==========================================================================
module bus_arbiter_rr_select
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS = 4
) (
  input  logic [NUM_MASTERS-1:0] request,
  input  logic [INDEX_W-1:0]     last_winner,
  output logic [INDEX_W-1:0]     winner,
  output logic                   found
);

  // Two ascending passes: indices above last_winner first, then the wrap-around.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!found && request[j] && (j > int'(last_winner))) begin
        found  = 1'b1;
        winner = INDEX_W'(j);
      end
    end
    for (int j = 0; j < NUM_MASTERS; j++) begin
      if (!found && request[j]) begin
        found  = 1'b1;
        winner = INDEX_W'(j);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter.sv
`default_nettype none
//==========================================================================
// Module : bus_arbiter
// Round-robin bus arbiter; BUS_ARBITER_TIMEOUT_EN adds a bus watchdog.
// Rev    : 1.0
//==========================================================================
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int NUM_MASTERS    = 4,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] request,
  output logic [NUM_MASTERS-1:0] grant,
  input  logic                   begin_transaction_in,
  input  logic                   end_transaction_in,
  input  logic                   data_valid_in,
  output logic                   end_transaction_out,
  output logic                   error_out,
  output logic [2:0]             active_master
);

  localparam logic [NUM_MASTERS-1:0] GRANT_LSB = NUM_MASTERS'(1);

  state_t             state;
  logic [INDEX_W-1:0] last_winner;
  logic [INDEX_W-1:0] rr_winner;
  logic               rr_found;

  bus_arbiter_rr_select #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_rr_select (
    .request     (request),
    .last_winner (last_winner),
    .winner      (rr_winner),
    .found       (rr_found)
  );

`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] watchdog;
  logic            forced_end;
  logic            activity;
  logic            timeout_hit;

  assign activity            = begin_transaction_in | data_valid_in;
  assign timeout_hit         = !activity && (watchdog == WD_W'(TIMEOUT_CYCLES - 1));
  assign end_transaction_out = forced_end;
  assign error_out           = forced_end;
`else
  logic unused_inputs;

  assign unused_inputs       = data_valid_in | (TIMEOUT_CYCLES == 0);
  assign end_transaction_out = 1'b0;
  assign error_out           = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= ST_IDLE;
      grant         <= '0;
      active_master <= '0;
      last_winner   <= last_index(NUM_MASTERS);
`ifdef BUS_ARBITER_TIMEOUT_EN
      watchdog      <= '0;
      forced_end    <= 1'b0;
`endif
    end else begin
`ifdef BUS_ARBITER_TIMEOUT_EN
      forced_end <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (rr_found) begin
            grant         <= GRANT_LSB << rr_winner;
            active_master <= 3'(rr_winner);
            last_winner   <= rr_winner;
            state         <= ST_GRANT;
`ifdef BUS_ARBITER_TIMEOUT_EN
            watchdog      <= '0;
`endif
          end
        end

        ST_GRANT: begin
          if (begin_transaction_in && end_transaction_in) begin
            grant         <= '0;
            active_master <= '0;
            state         <= ST_RELEASE;
          end else if (begin_transaction_in) begin
            state <= ST_BUSY;
`ifdef BUS_ARBITER_TIMEOUT_EN
            watchdog <= '0;
`endif
          end else if ((request & grant) == '0) begin
            // Winner gave up before starting; re-arbitrate straight away.
            grant         <= '0;
            active_master <= '0;
            state         <= ST_IDLE;
          end
`ifdef BUS_ARBITER_TIMEOUT_EN
          else if (timeout_hit) begin
            grant         <= '0;
            active_master <= '0;
            forced_end    <= 1'b1;
            state         <= ST_RELEASE;
          end else begin
            watchdog <= activity ? '0 : watchdog + 1'b1;
          end
`endif
        end

        ST_BUSY: begin
          // Request changes are deliberately ignored while the bus is owned.
          if (end_transaction_in) begin
            grant         <= '0;
            active_master <= '0;
            state         <= ST_RELEASE;
          end
`ifdef BUS_ARBITER_TIMEOUT_EN
          else if (timeout_hit) begin
            grant         <= '0;
            active_master <= '0;
            forced_end    <= 1'b1;
            state         <= ST_RELEASE;
          end else begin
            watchdog <= activity ? '0 : watchdog + 1'b1;
          end
`endif
        end

        ST_RELEASE: begin
          state <= ST_IDLE;
        end

        default: begin
          grant         <= '0;
          active_master <= '0;
          state         <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter.sv
`default_nettype none
//==========================================================================
// Module : tb_bus_arbiter
// Scoreboard bench for bus_arbiter (4 masters, watchdog limit 8).
// Rev    : 1.0
//==========================================================================
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int IW = $clog2(N);
  localparam int TO = 8;
`ifdef BUS_ARBITER_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic [N-1:0] request = '0;
  logic         begin_t = 1'b0;
  logic         end_t = 1'b0;
  logic         dv = 1'b0;
  logic [N-1:0] grant;
  logic         eto;
  logic         err;
  logic [2:0]   active_master;

  bus_arbiter #(
    .NUM_MASTERS    (N),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clock                (clock),
    .reset                (reset),
    .request              (request),
    .grant                (grant),
    .begin_transaction_in (begin_t),
    .end_transaction_in   (end_t),
    .data_valid_in        (dv),
    .end_transaction_out  (eto),
    .error_out            (err),
    .active_master        (active_master)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [N-1:0] grant;
    logic [2:0]   am;
    logic         forced;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Spec-level reference state: 0 idle, 1 grant, 2 busy, 3 release.
  int m_state = 0;
  int m_idx   = -1;
  int m_last  = N - 1;
  int m_wd    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    exp_t e;
    bit   forced = 1'b0;
    bit   act    = begin_t || dv;
    bit   expire = TO_EN && !act && (m_wd == TO - 1);
    if (reset) begin
      m_state = 0; m_idx = -1; m_last = N - 1; m_wd = 0;
    end else begin
      case (m_state)
        0: for (int k = 1; k <= N; k++) begin
             int c;
             c = (m_last + k) % N;
             if (m_state == 0 && request[c[IW-1:0]]) begin
               m_idx = c; m_last = c; m_state = 1; m_wd = 0;
             end
           end
        1: if (begin_t && end_t) begin m_state = 3; m_idx = -1; end
           else if (begin_t) begin m_state = 2; m_wd = 0; end
           else if (!request[m_idx[IW-1:0]]) begin m_state = 0; m_idx = -1; end
           else if (expire) begin m_state = 3; m_idx = -1; forced = 1'b1; end
           else m_wd = act ? 0 : m_wd + 1;
        2: if (end_t) begin m_state = 3; m_idx = -1; end
           else if (expire) begin m_state = 3; m_idx = -1; forced = 1'b1; end
           else m_wd = act ? 0 : m_wd + 1;
        default: m_state = 0;
      endcase
    end
    e.grant  = (m_idx < 0) ? '0 : (N'(1) << m_idx);
    e.am     = (m_idx < 0) ? 3'd0 : 3'(m_idx);
    e.forced = forced;
    sb.push_back(e);
  endtask

  // One clock: predict, let the edge happen, compare, return at the negedge.
  task automatic tick();
    exp_t e;
    model_step();
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("grant", 32'(grant), 32'(e.grant));
    check("active_master", 32'(active_master), 32'(e.am));
    check("end_transaction_out", 32'(eto), 32'(e.forced));
    check("error_out", 32'(err), 32'(e.forced));
    check("grant_onehot0", 32'($onehot0(grant)), 32'd1);
    @(negedge clock);
  endtask

  task automatic wait_grant(output int n);
    n = 0;
    while (grant == '0 && n < 12) begin
      tick();
      n++;
    end
    if (grant == '0) check("grant_wait_timeout", 32'(grant != '0), 32'd1);
  endtask

  task automatic txn(input int beats, input bit drop_mid);
    begin_t = 1'b1;
    tick();
    begin_t = 1'b0;
    dv = 1'b1;
    for (int b = 0; b < beats; b++) begin
      if (drop_mid && b == 1) request = '0;
      tick();
    end
    dv = 1'b0;
    end_t = 1'b1;
    tick();
    end_t = 1'b0;
  endtask

  int gap;
  int order[5];
  int exp_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    // Reset state and first-grant latency.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    request = 4'b0001;
    tick();
    check("r031_grant", 32'(grant), 32'h1);
    check("r031_active_master", 32'(active_master), 32'd0);
    request = '0;
    tick();
    check("abandon_to_idle", 32'(grant), 32'h0);

    // Round-robin order and inter-grant gap with all masters requesting.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    request = '1;
    for (int i = 0; i < 5; i++) begin
      wait_grant(gap);
      order[i] = int'(active_master);
      if (i > 0) check("r032_gap", 32'(gap), 32'd2);
      txn(4, i == 1);
      check("r032_released", 32'(grant), 32'h0);
      request = '1;
    end
    for (int i = 0; i < 5; i++) check("r032_order", 32'(order[i]), 32'(exp_order[i]));

    // Abandoned grant: master 2 drops before begin, master 3 follows.
    reset = 1'b1;
    request = '0;
    tick();
    reset = 1'b0;
    request = 4'b0100;
    tick();
    check("r033_grant2", 32'(grant), 32'h4);
    request = 4'b1000;
    tick();
    check("r033_dropped", 32'(grant), 32'h0);
    tick();
    check("r033_grant3", 32'(grant), 32'h8);
    check("r033_am3", 32'(active_master), 32'd3);

    // Begin and end in the same GRANT cycle.
    begin_t = 1'b1;
    end_t = 1'b1;
    tick();
    begin_t = 1'b0;
    end_t = 1'b0;
    check("r034_release", 32'(grant), 32'h0);
    tick();
    check("r034_no_arb_in_release", 32'(grant), 32'h0);
    tick();
    check("r034_regrant", 32'(grant), 32'h8);

    // Reset mid-transaction drops grant and restarts arbitration at master 0.
    request = '0;
    tick();
    request = 4'b0100;
    tick();
    check("r036_grant2", 32'(grant), 32'h4);
    begin_t = 1'b1;
    tick();
    begin_t = 1'b0;
    dv = 1'b1;
    tick();
    check("r036_busy_hold", 32'(grant), 32'h4);
    dv = 1'b0;
    reset = 1'b1;
    request = '1;
    tick();
    check("r036_reset_drop", 32'(grant), 32'h0);
    reset = 1'b0;
    tick();
    check("r036_master0_first", 32'(grant), 32'h1);

    // Bus stalls in BUSY with no data_valid.
    begin_t = 1'b1;
    tick();
    begin_t = 1'b0;
`ifdef BUS_ARBITER_TIMEOUT_EN
    for (int k = 0; k < TO - 1; k++) tick();
    check("r035_pre_timeout_grant", 32'(grant), 32'h1);
    check("r035_pre_timeout_eto", 32'(eto), 32'd0);
    tick();
    check("r035_timeout_eto", 32'(eto), 32'd1);
    check("r035_timeout_err", 32'(err), 32'd1);
    check("r035_timeout_grant", 32'(grant), 32'h0);
    tick();
    check("r035_pulse_one_cycle", 32'(eto), 32'd0);
`else
    for (int k = 0; k < 3 * TO; k++) tick();
    check("r035_grant_held", 32'(grant), 32'h1);
    check("r035_no_forced_end", 32'(eto), 32'd0);
    end_t = 1'b1;
    tick();
    end_t = 1'b0;
`endif

    // Random traffic against the reference model.
    for (int k = 0; k < 400; k++) begin
      reset   = ($urandom_range(0, 80) == 0);
      request = N'($urandom);
      begin_t = ($urandom_range(0, 3) == 0);
      end_t   = ($urandom_range(0, 4) == 0);
      dv      = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
